vec_reg_loader: RTL

VEC_REG_LOADER -- requirements
Module: vec_reg_loader

---
 rtl/vec_reg_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vec_reg_loader.sv
// Gathers three strided pixels from memory, extends each to 18 bits and
// writes them as one 3-lane vector into the vector register file.
module vec_reg_loader #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [3:0]        cmd_dest,
  input  logic              cmd_signed,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              we3,
  output logic [3:0]        ra3,
  output logic [2:0][17:0]  wd3,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LANE_W = 18;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  FIRST_PROT = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_ERR
  } state_t;

  state_t                  r_state, w_state_nx;
  logic [ADDR_W-1:0]       r_stride, w_stride_nx;
  logic [3:0]              r_dest, w_dest_nx;
  logic                    r_signed, w_signed_nx;
  logic [1:0]              r_lane_idx, w_lane_idx_nx;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
  logic [2:0][LANE_W-1:0]  r_lane, w_lane_nx;
  logic [ADDR_W-1:0]       r_mem_addr, w_mem_addr_nx;
  logic [3:0]              r_ra3, w_ra3_nx;
  logic [2:0][LANE_W-1:0]  r_wd3, w_wd3_nx;
  logic                    r_mem_req, r_we3, r_busy, r_done, r_err, r_cmd_ready;
  logic [LANE_W-1:0]       w_ext;

  assign w_ext = r_signed ? LANE_W'($signed(mem_rdata)) : LANE_W'(mem_rdata);

  // Next-state and next-register computation; all outputs follow the next state.
  always_comb begin
    w_state_nx    = r_state;
    w_stride_nx   = r_stride;
    w_dest_nx     = r_dest;
    w_signed_nx   = r_signed;
    w_lane_idx_nx = r_lane_idx;
    w_cnt_nx      = r_cnt;
    w_lane_nx     = r_lane;
    w_mem_addr_nx = r_mem_addr;
    w_ra3_nx      = r_ra3;
    w_wd3_nx      = r_wd3;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_stride_nx   = cmd_stride;
          w_dest_nx     = cmd_dest;
          w_signed_nx   = cmd_signed;
          w_lane_idx_nx = 2'd0;
          w_cnt_nx      = '0;
          w_lane_nx     = '0;
          if (cmd_dest >= FIRST_PROT) begin
            w_state_nx = S_ERR;
          end else begin
            w_state_nx    = S_FETCH;
            w_mem_addr_nx = cmd_base;
          end
        end
      end
      S_FETCH: w_state_nx = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          w_lane_nx[r_lane_idx] = w_ext;
          if (r_lane_idx == 2'd2) begin
            w_state_nx = S_WRITE;
            w_wd3_nx   = w_lane_nx;
            w_ra3_nx   = r_dest;
          end else begin
            w_state_nx    = S_FETCH;
            w_lane_idx_nx = r_lane_idx + 2'd1;
            w_cnt_nx      = '0;
            w_mem_addr_nx = r_mem_addr + r_stride;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_state_nx = S_ERR;
          end
        end
      end
      S_WRITE: w_state_nx = S_IDLE;
      S_ERR:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_stride    <= '0;
      r_dest      <= '0;
      r_signed    <= 1'b0;
      r_lane_idx  <= 2'd0;
      r_cnt       <= '0;
      r_lane      <= '0;
      r_mem_addr  <= '0;
      r_ra3       <= '0;
      r_wd3       <= '0;
      r_mem_req   <= 1'b0;
      r_we3       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_stride    <= w_stride_nx;
      r_dest      <= w_dest_nx;
      r_signed    <= w_signed_nx;
      r_lane_idx  <= w_lane_idx_nx;
      r_cnt       <= w_cnt_nx;
      r_lane      <= w_lane_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_ra3       <= w_ra3_nx;
      r_wd3       <= w_wd3_nx;
      r_mem_req   <= (w_state_nx == S_FETCH);
      r_we3       <= (w_state_nx == S_WRITE);
      r_done      <= (w_state_nx == S_WRITE);
      r_err       <= (w_state_nx == S_ERR);
      r_busy      <= (w_state_nx != S_IDLE);
      r_cmd_ready <= (w_state_nx == S_IDLE);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign we3       = r_we3;
  assign ra3       = r_ra3;
  assign wd3       = r_wd3;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
